fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage of the PIGRO pipeline, and the upstream end of the fetch→decode interface.
- Generates a 5-bit program counter.
- Issues single-word requests to instruction memory, buffers responses in a small prefetch queue, and presents {instruction, pc} to decode.
- Obeys decode's stall (hold outputs) and jump_flag/jump_dest (redirect and flush).
- Max one memory request outstanding.

Parameters:
PC_W, 5, program counter / instruction address width; addresses wrap modulo 2^PC_W.
DEPTH, 2, prefetch queue entries (each holds instruction + pc); legal range 1..4.
NOP_WORD, 32'h0000_0000, instruction word driven to decode when no valid instruction is available.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  1  from decode; 1 = hold instruction_out/pc_out and do not pop the queue.
jump_flag  in  1  from decode; 1 = redirect fetch to jump_dest this cycle.
jump_dest  in  PC_W  redirect target address.
imem_req  out  1  one-cycle request pulse to instruction memory.
imem_addr  out  PC_W  request address; valid only while imem_req=1.
imem_valid  in  1  one-cycle response strobe; arrives ≥1 cycle after imem_req.
imem_data  in  32  response instruction word; valid with imem_valid.
instruction_out  out  32  instruction to decode (instruction_in of decode).
pc_out  out  PC_W  pc of instruction_out (pc_in of decode).
fetch_valid  out  1  1 = instruction_out is a real fetched word, 0 = NOP_WORD bubble.

Behaviour:
Reset (asynchronous, rst=1):
- fetch_pc=0, queue empty, outstanding=0, FSM=RUN.
- Outputs: imem_req=0, imem_addr=0, instruction_out=NOP_WORD, pc_out=0, fetch_valid=0.
- First request issues in the first clock after rst deasserts.

FSM states:
- RUN: no request outstanding.
- WAIT: request outstanding; response will be kept.
- DISCARD: request outstanding; response will be dropped.
- RUN→WAIT on issue.
- WAIT→RUN on imem_valid, or WAIT→WAIT if a new request issues in the same cycle.
- WAIT→DISCARD on jump_flag without imem_valid.
- DISCARD→RUN on imem_valid, or DISCARD→WAIT if a new request issues in the same cycle.

Response handling:
- imem_valid in WAIT pushes {imem_data, tag_pc} to the queue tail. tag_pc is the address of that request.
- imem_valid in RUN (spurious) is ignored.
- imem_valid in DISCARD is dropped.

Pop / output:
- Each clock with stall=0 and jump_flag=0:
  - Queue non-empty: pop head to instruction_out/pc_out, fetch_valid=1.
  - Queue empty: instruction_out=NOP_WORD, fetch_valid=0, pc_out held.
- A response arriving into an empty queue becomes visible on the output no earlier than the next clock (no bypass).
- stall=1: instruction_out, pc_out, fetch_valid all held; no pop; fetching continues until the queue is full.

Issue rule:
- imem_req=1 in a cycle iff, after this cycle's response and jump handling, no request remains outstanding and (count − pop + push) < DEPTH.
- When issuing: imem_addr=fetch_pc; fetch_pc increments modulo 2^PC_W (31→0 for PC_W=5).
- Latency-1 memory with stall=0 sustains one instruction per cycle.

Redirect (jump_flag=1):
- Sampled on clk; has priority over stall and over any same-cycle response.
- Queue cleared; instruction_out=NOP_WORD, fetch_valid=0, pc_out=jump_dest.
- If a request is outstanding and not completing this cycle, enter DISCARD.
- If the response completes this cycle, it is dropped.
- fetch_pc=jump_dest. A new request to jump_dest issues in the same cycle if no request remains outstanding; otherwise in the cycle after the discarded response.

Invariants:
- Queue occupancy never exceeds DEPTH; at most 1 outstanding request.
- pc_out of consecutive valid outputs differs by +1 modulo 2^PC_W except across a redirect.

Reset mid-operation:
- Immediate return to reset values.
- A memory response arriving while rst=1, or after reset with no request outstanding, is ignored.

Test Plan:
1. Reset release, memory latency 1 returning word = 0xA000_0000+addr, stall=0 → imem_addr 0,1,2,… on consecutive cycles; instruction_out A000_0000, A000_0001,… with pc_out 0,1,2 at one per cycle after the initial fill; fetch_valid=1 from first output onward.
2. stall=1 for 4 cycles while instruction_out=A000_0003/pc 3, DEPTH=2 → outputs held; exactly 2 more requests issued (addr 4,5), then imem_req=0; on release, pc_out 4,5,6 on consecutive cycles.
3. Memory latency 3; jump_flag=1 with jump_dest=20 one cycle after a request to addr 7 → that response is dropped; next imem_addr=20; no instruction with pc 7 reaches the output; pc_out sequence resumes 20,21.
4. jump_flag=1 asserted together with stall=1 and a coincident imem_valid → queue empty, fetch_valid=0, instruction_out=NOP_WORD, request to jump_dest issued in the same cycle.
5. Start via jump to 30, latency 1 → imem_addr 30,31,0,1; pc_out 30,31,0,1.
6. Assert rst asynchronously mid-cycle while WAIT with a queue of 2 → outputs return to reset values immediately without a clock edge; a late imem_valid during/after reset is ignored; fetch restarts at addr 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding memory requests,
// a small prefetch queue and the {instruction, pc} hand-off to decode.
module fetch_unit #(
  parameter int          PC_W     = 5,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            jump_flag,
  input  logic [PC_W-1:0] jump_dest,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instruction_out,
  output logic [PC_W-1:0] pc_out,
  output logic            fetch_valid
);

  // Handshake: imem_req is a one-cycle pulse carrying imem_addr; the matching
  // imem_valid/imem_data strobe comes back one or more cycles later. Only one
  // request may be outstanding; decode's stall holds the output registers.

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DISCARD} state_t;

  localparam logic [2:0]      DEPTH_C = 3'(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE  = 1;

  state_t            state, state_n;
  logic [PC_W-1:0]   fetch_pc, fetch_pc_n;
  logic [PC_W-1:0]   tag_pc, tag_pc_n;
  logic [2:0]        count, count_n, wr_idx;
  logic [31:0]       q_instr   [DEPTH];
  logic [31:0]       q_instr_n [DEPTH];
  logic [PC_W-1:0]   q_pc      [DEPTH];
  logic [PC_W-1:0]   q_pc_n    [DEPTH];

  logic              pop, push, pending, issue;
  logic [PC_W-1:0]   req_addr;

  always_comb begin
    pop      = !jump_flag && !stall && (count != 3'd0);
    push     = imem_valid && (state == S_WAIT) && !jump_flag;
    // A request stays outstanding unless its response lands this cycle.
    pending  = (state != S_RUN) && !imem_valid;
    count_n  = jump_flag ? 3'd0 : (count - {2'b00, pop} + {2'b00, push});
    issue    = !rst && !pending && (count_n < DEPTH_C);
    req_addr = jump_flag ? jump_dest : fetch_pc;
    wr_idx   = count - {2'b00, pop};

    imem_req  = issue;
    imem_addr = issue ? req_addr : '0;

    state_n = S_RUN;
    if (issue)        state_n = S_WAIT;
    else if (pending) state_n = (jump_flag || state == S_DISCARD) ? S_DISCARD : S_WAIT;

    fetch_pc_n = issue ? (req_addr + PC_ONE) : req_addr;
    tag_pc_n   = issue ? req_addr : tag_pc;

    for (int i = 0; i < DEPTH; i++) begin
      q_instr_n[i] = q_instr[i];
      q_pc_n[i]    = q_pc[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_instr_n[i] = q_instr[i+1];
        q_pc_n[i]    = q_pc[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == 3'(i)) begin
          q_instr_n[i] = imem_data;
          q_pc_n[i]    = tag_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      fetch_pc <= '0;
      tag_pc   <= '0;
      count    <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      tag_pc   <= tag_pc_n;
      count    <= count_n;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= q_instr_n[i];
        q_pc[i]    <= q_pc_n[i];
      end
    end
  end

  // Redirect wins over stall; an empty queue yields a bubble with pc held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_out <= NOP_WORD;
      pc_out          <= '0;
      fetch_valid     <= 1'b0;
    end else if (jump_flag) begin
      instruction_out <= NOP_WORD;
      pc_out          <= jump_dest;
      fetch_valid     <= 1'b0;
    end else if (!stall) begin
      if (count != 3'd0) begin
        instruction_out <= q_instr[0];
        pc_out          <= q_pc[0];
        fetch_valid     <= 1'b1;
      end else begin
        instruction_out <= NOP_WORD;
        fetch_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory whose
// response word is 0xA000_0000 + address and whose latency is selectable.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        jump_flag = 1'b0;
  logic [4:0]  jump_dest = '0;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] instruction_out;
  logic [4:0]  pc_out;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          lat = 1;
  int          mem_cnt = 0;
  logic [4:0]  pend_addr = '0;
  logic        mem_valid = 1'b0;
  logic        saw_req = 1'b0;
  logic [4:0]  saw_addr = '0;
  logic        force_valid = 1'b0;
  logic [31:0] force_data = '0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_flag(jump_flag), .jump_dest(jump_dest),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .instruction_out(instruction_out), .pc_out(pc_out), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    saw_req  = imem_req;
    saw_addr = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (mem_cnt > 0) mem_cnt = mem_cnt - 1;
    if (saw_req) begin
      pend_addr = saw_addr;
      mem_cnt   = lat;
      saw_req   = 1'b0;
    end
    mem_valid = (mem_cnt == 1);
  end

  assign imem_valid = mem_valid | force_valid;
  assign imem_data  = force_valid ? force_data : (32'hA000_0000 + {27'b0, pend_addr});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [4:0] pc);
    chk({tag, "_valid"}, {31'b0, fetch_valid}, {31'b0, v});
    chk({tag, "_instr"}, instruction_out, ins);
    chk({tag, "_pc"}, {27'b0, pc_out}, {27'b0, pc});
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [4:0] a);
    chk({tag, "_req"}, {31'b0, imem_req}, {31'b0, r});
    if (r) chk({tag, "_addr"}, {27'b0, imem_addr}, {27'b0, a});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_req(tag, 1'b0, 5'd0);
    chk({tag, "_addr0"}, {27'b0, imem_addr}, 32'd0);
    chk_out(tag, 1'b0, NOP, 5'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the caller 2 time units into cycle c0, the first cycle out of reset.
  task automatic apply_reset(input int l);
    rst = 1'b1;
    stall = 1'b0;
    jump_flag = 1'b0;
    force_valid = 1'b0;
    repeat (5) next_cycle();
    sample();
    chk_reset_vals("reset");
    lat = l;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // Segment A: latency-1 streaming, stall hold, jump with stall and response
    apply_reset(1);
    sample();
    chk_req("t1_c0", 1'b1, 5'd0);
    chk_out("t1_c0", 1'b0, NOP, 5'd0);
    for (int n = 1; n <= 5; n++) begin
      next_cycle();
      sample();
      chk_req("t1_stream", 1'b1, 5'(n));
      if (n >= 3) chk_out("t1_stream", 1'b1, 32'hA000_0000 + 32'(n - 3), 5'(n - 3));
      else        chk_out("t1_fill", 1'b0, NOP, 5'd0);
    end

    next_cycle();
    stall = 1'b1;
    sample();
    chk_req("t2_full", 1'b0, 5'd0);
    chk_out("t2_hold", 1'b1, 32'hA000_0003, 5'd3);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      chk_req("t2_stalled", 1'b0, 5'd0);
      chk_out("t2_hold", 1'b1, 32'hA000_0003, 5'd3);
    end
    next_cycle();
    stall = 1'b0;
    sample();
    chk_req("t2_release", 1'b1, 5'd6);
    chk_out("t2_release", 1'b1, 32'hA000_0003, 5'd3);
    next_cycle();
    sample();
    chk_req("t2_r1", 1'b1, 5'd7);
    chk_out("t2_r1", 1'b1, 32'hA000_0004, 5'd4);
    next_cycle();
    sample();
    chk_req("t2_r2", 1'b1, 5'd8);
    chk_out("t2_r2", 1'b1, 32'hA000_0005, 5'd5);

    next_cycle();
    jump_flag = 1'b1;
    stall = 1'b1;
    jump_dest = 5'd12;
    sample();
    chk_req("t4_jump", 1'b1, 5'd12);
    chk_out("t4_pre", 1'b1, 32'hA000_0006, 5'd6);
    next_cycle();
    jump_flag = 1'b0;
    stall = 1'b0;
    sample();
    chk_out("t4_flushed", 1'b0, NOP, 5'd12);
    chk_req("t4_next", 1'b1, 5'd13);
    next_cycle();
    sample();
    chk_out("t4_bubble", 1'b0, NOP, 5'd12);
    chk_req("t4_next2", 1'b1, 5'd14);
    next_cycle();
    sample();
    chk_out("t4_first", 1'b1, 32'hA000_000C, 5'd12);
    next_cycle();
    sample();
    chk_out("t4_second", 1'b1, 32'hA000_000D, 5'd13);

    // Segment B: latency 3, redirect while the request to 7 is in flight
    apply_reset(3);
    sample();
    chk_req("t3_c0", 1'b1, 5'd0);
    for (int n = 1; n <= 21; n++) begin
      next_cycle();
      sample();
      if (n == 3)  chk_req("t3_c3", 1'b1, 5'd1);
      if (n == 4)  chk_req("t3_c4", 1'b0, 5'd0);
      if (n == 5)  chk_out("t3_c5", 1'b1, 32'hA000_0000, 5'd0);
      if (n == 21) chk_req("t3_req7", 1'b1, 5'd7);
    end
    next_cycle();
    jump_flag = 1'b1;
    jump_dest = 5'd20;
    sample();
    chk_req("t3_jump", 1'b0, 5'd0);
    next_cycle();
    jump_flag = 1'b0;
    sample();
    chk_req("t3_discard", 1'b0, 5'd0);
    chk_out("t3_c23", 1'b0, NOP, 5'd20);
    next_cycle();
    sample();
    chk_req("t3_redirect", 1'b1, 5'd20);
    chk_out("t3_c24", 1'b0, NOP, 5'd20);
    for (int k = 25; k <= 32; k++) begin
      next_cycle();
      sample();
      if (k == 27) chk_req("t3_req21", 1'b1, 5'd21);
      if (k == 29)      chk_out("t3_pc20", 1'b1, 32'hA000_0014, 5'd20);
      else if (k == 32) chk_out("t3_pc21", 1'b1, 32'hA000_0015, 5'd21);
      else              chk_out("t3_bubble", 1'b0, NOP, 5'd20);
    end

    // Segment C: start by jumping to 30, wrap, then asynchronous reset
    apply_reset(1);
    jump_flag = 1'b1;
    jump_dest = 5'd30;
    sample();
    chk_req("t5_c0", 1'b1, 5'd30);
    next_cycle();
    jump_flag = 1'b0;
    sample();
    chk_req("t5_c1", 1'b1, 5'd31);
    chk_out("t5_c1", 1'b0, NOP, 5'd30);
    next_cycle();
    sample();
    chk_req("t5_wrap", 1'b1, 5'd0);
    chk_out("t5_c2", 1'b0, NOP, 5'd30);
    next_cycle();
    sample();
    chk_req("t5_c3", 1'b1, 5'd1);
    chk_out("t5_pc30", 1'b1, 32'hA000_001E, 5'd30);
    next_cycle();
    sample();
    chk_out("t5_pc31", 1'b1, 32'hA000_001F, 5'd31);
    next_cycle();
    sample();
    chk_out("t5_pc0", 1'b1, 32'hA000_0000, 5'd0);
    next_cycle();
    sample();
    chk_req("t5_c6", 1'b1, 5'd4);
    chk_out("t5_pc1", 1'b1, 32'hA000_0001, 5'd1);

    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    next_cycle();
    sample();
    chk_reset_vals("t6_late_resp");
    next_cycle();
    rst = 1'b0;
    force_valid = 1'b1;
    force_data = 32'hDEAD_BEEF;
    sample();
    chk_req("t6_restart", 1'b1, 5'd0);
    chk_out("t6_c8", 1'b0, NOP, 5'd0);
    next_cycle();
    force_valid = 1'b0;
    sample();
    chk_req("t6_c9", 1'b1, 5'd1);
    chk_out("t6_c9", 1'b0, NOP, 5'd0);
    next_cycle();
    sample();
    chk_req("t6_c10", 1'b1, 5'd2);
    chk_out("t6_c10", 1'b0, NOP, 5'd0);
    next_cycle();
    sample();
    chk_out("t6_pc0", 1'b1, 32'hA000_0000, 5'd0);
    next_cycle();
    sample();
    chk_out("t6_pc1", 1'b1, 32'hA000_0001, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
